// File: rtl/memory_writeback.sv
// memory_writeback
//   Write side of the Game of Life cell memory. Next-generation 24-bit cell
//   words arrive tagged with row/column counters. They are queued in a small
//   FIFO and written into the bank that the reader is not using. Writes are
//   held off while the read controller owns the RAM port. A flush drains the
//   FIFO, pulses done_out and flips the bank.
//
// Ports
//   clk_in        clock, all logic on posedge
//   rst_in        asynchronous active-high reset
//   data_in       next-generation cell word (24b)
//   hangcount     row index of the word (5b)
//   Ycount        column index of the word (7b)
//   valid_in      data_in/hangcount/Ycount valid
//   ready_out     word accepted on a posedge with valid_in && ready_out
//   rd_active_in  read controller owns the RAM port; no write may issue
//   flush_in      one-cycle end-of-generation pulse
//   write_addr    RAM write address (13b)
//   write_data    RAM write data (24b)
//   write_en      RAM write strobe, one word per high cycle
//   bank_out      bank currently being written; the reader uses ~bank_out
//   done_out      one-cycle pulse when a flush completes
module memory_writeback #(
    parameter int FIFO_DEPTH  = 4,
    parameter int BANK_OFFSET = 4096
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [23:0] data_in,
    input  logic [4:0]  hangcount,
    input  logic [6:0]  Ycount,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        rd_active_in,
    input  logic        flush_in,
    output logic [12:0] write_addr,
    output logic [23:0] write_data,
    output logic        write_en,
    output logic        bank_out,
    output logic        done_out
);

    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [12:0] BANK_ADD = 13'(BANK_OFFSET);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [11:0] offset;
        logic [23:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    // Input is closed once a flush has been seen, so the drain terminates.
    assign ready_out = ((state == IDLE) || (state == RUN)) && !full;
    assign push      = valid_in && ready_out;
    assign pop       = !empty && !rd_active_in;
    assign done_out  = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (flush_in) state_nxt = DRAIN;
                     else if (push) state_nxt = RUN;
            RUN:     if (flush_in) state_nxt = DRAIN;
            // A pop at this edge leaves empty low, so DONE comes one edge
            // after the last write issues.
            DRAIN:   if (empty) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= '{offset: {hangcount, Ycount}, data: data_in};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            bank_out   <= 1'b0;
        end else begin
            state    <= state_nxt;
            write_en <= pop;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                write_addr <= {1'b0, mem[rd_ptr].offset} + (bank_out ? BANK_ADD : 13'd0);
                write_data <= mem[rd_ptr].data;
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // FIFO is empty and input closed during DONE, so no word can
            // issue with a stale bank.
            if (state == DONE) bank_out <= ~bank_out;
        end
    end

endmodule
